vreg_wb_arbiter: RTL and testbench
==================================

// Module: vreg_wb_arbiter
// PURPOSE
//  Write-side initiator for the vector register file: merges ALU results and load (MEM) returns into
//  one registered write per cycle (reg_write/write_reg/write_data). MEM returns are buffered in a
//  small FIFO; the ALU path is unbuffered. Provides a busy query so issue logic can stall on
//  registers with pending writes. Sits between execute/memory stages and the register file.
// PARAMETERS
//  DATA_W      32  register width
//  ADDR_W      5   register index width
//  FIFO_DEPTH  4   MEM return buffer entries; power of two, >=2
// PORTS
//  clk         in   1                     single clock, rising edge
//  rst         in   1                     asynchronous, active-high reset
//  alu_valid   in   1                     ALU result offered
//  alu_ready   out  1                     ALU result accepted this cycle when alu_valid&alu_ready
//  alu_reg     in   ADDR_W                ALU destination register
//  alu_data    in   DATA_W                ALU result
//  mem_valid   in   1                     load return offered
//  mem_ready   out  1                     FIFO can accept
//  mem_reg     in   ADDR_W                load destination register
//  mem_data    in   DATA_W                load data
//  reg_write   out  1                     register-file write strobe, one cycle per write
//  write_reg   out  ADDR_W                write index
//  write_data  out  DATA_W                write data
//  busy_q_reg  in   ADDR_W                busy query index
//  busy_q      out  1                     pending write exists for busy_q_reg (comb.)
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (async, rst=1): FIFO empty, state NORM, reg_write=0, write_reg=0, write_data=0,
//    fifo_count=0; FIFO contents discarded, including mid-drain. Outputs valid immediately.
//  - FSM: NORM, DRAIN. NORM->DRAIN at edge where FIFO becomes full (count==FIFO_DEPTH).
//    DRAIN->NORM at edge where the pop leaves count==0.
//  - NORM: alu_ready=1, mem_ready=(count<FIFO_DEPTH). Output selection: ALU handshake wins;
//    else pop FIFO head if count>0. DRAIN: alu_ready=0, mem_ready=0, pop one entry per cycle.
//  - MEM accept pushes {mem_reg,mem_data} at tail; no fall-through: entry is poppable the next cycle.
//    Push and pop in the same cycle allowed; count unchanged.
//  - Output stage registered: selected entry appears on write_reg/write_data with reg_write=1 in the
//    cycle after selection. Latency ALU 1 cycle, MEM >=2 cycles. When reg_write=0, write_reg and
//    write_data hold their last values.
//  - Register 0: requests with destination 0 are handshaken normally but never enqueued nor
//    written (reg_write stays 0 for them); busy_q=0 for busy_q_reg==0.
//  - busy_q=1 if busy_q_reg (!=0) matches any valid FIFO entry or the output stage while reg_write=1.
//  - FIFO entries written in acceptance order; ALU vs MEM ordering to the same register is the
//    issue logic's duty via busy_q.
// CONFIGURATION
//  VREG_WB_FWD_EN defined: adds outputs fwd_hit (1) and fwd_data (DATA_W): for busy_q_reg, youngest
//  matching FIFO entry's data, else output-stage data if reg_write=1; fwd_hit=busy_q.
//  Undefined: ports and forwarding mux absent; all other behaviour identical.
// STRUCTURE
//  Package vreg_wb_pkg: DATA_W/ADDR_W defaults, FSM state encoding (NORM=0, DRAIN=1),
//  wb_entry_t {reg idx, data}.
//  Sub-module vreg_wb_fifo: FIFO_DEPTH-entry wb_entry_t FIFO, async reset, exposes per-entry valid/reg
//  for the busy/forward compare. Arbiter FSM and output stage in top.
// TESTING
//  1. ALU only: alu_reg=3,data=0xA5A5_0001 -> next cycle reg_write=1, write_reg=3, write_data=0xA5A5_0001.
//  2. MEM burst of 4 with alu_valid held -> FIFO fills, DRAIN entered, alu_ready=0, 4 writes in order,
//     back to NORM when count=0.
//  3. ALU and MEM same cycle, FIFO empty -> ALU written cycle+1, MEM cycle+2; busy_q set for mem_reg until written.
//  4. Writes to r0 from both ports -> handshakes complete, reg_write never 1, busy_q(0)=0.
//  5. rst pulsed mid-drain with count=3 -> reg_write=0 and fifo_count=0 immediately, state NORM.
//  6. FWD_EN: two pending MEM writes to r7 (0x11, 0x22) -> fwd_hit=1, fwd_data=0x22.

Source files
------------

// File: rtl/vreg_wb_pkg.sv
// Shared types for the vector register write-back arbiter:
// default widths, arbiter state encoding and the buffered write entry.
package vreg_wb_pkg;

  localparam int VW_DATA_W = 32;
  localparam int VW_ADDR_W = 5;

  typedef enum logic {
    NORM  = 1'b0,
    DRAIN = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [VW_ADDR_W-1:0] idx;
    logic [VW_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/vreg_wb_fifo.sv
// Load-return buffer for the write-back arbiter. Ports: clk/rst,
// i_push/i_push_reg/i_push_data (tail write), i_pop (head read),
// o_head_reg/o_head_data, o_count, per-entry o_vld/o_reg for busy compare;
// with VREG_WB_FWD_EN also o_data and o_rd_ptr for the forwarding mux.
module vreg_wb_fifo
  import vreg_wb_pkg::*;
#(
  parameter int DATA_W = VW_DATA_W,
  parameter int ADDR_W = VW_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_reg,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_head_reg,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CW-1:0]     o_count,
  output logic              o_vld [DEPTH],
  output logic [ADDR_W-1:0] o_reg [DEPTH]
`ifdef VREG_WB_FWD_EN
  ,
  output logic [DATA_W-1:0] o_data [DEPTH],
  output logic [PW-1:0]     o_rd_ptr
`endif
);

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_vld  [DEPTH];
  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (i_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      if (i_push) begin
        r_vld[r_wr_ptr]  <= 1'b1;
        r_reg[r_wr_ptr]  <= i_push_reg;
        r_data[r_wr_ptr] <= i_push_data;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head_reg  = r_reg[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_count     = r_count;
  assign o_vld       = r_vld;
  assign o_reg       = r_reg;
`ifdef VREG_WB_FWD_EN
  assign o_data      = r_data;
  assign o_rd_ptr    = r_rd_ptr;
`endif

endmodule

// File: rtl/vreg_wb_arbiter.sv
// Merges ALU results and buffered load returns into one registered
// register-file write per cycle, with a busy query for issue stalls.
// Ports: alu_* (unbuffered), mem_* (FIFO), reg_write/write_reg/write_data,
// busy_q_reg/busy_q, fifo_count. VREG_WB_FWD_EN adds fwd_hit/fwd_data.
module vreg_wb_arbiter
  import vreg_wb_pkg::*;
#(
  parameter int DATA_W     = VW_DATA_W,
  parameter int ADDR_W     = VW_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] busy_q_reg,
  output logic              busy_q,
`ifdef VREG_WB_FWD_EN
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [CW-1:0]     fifo_count
);

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;

  logic              w_alu_ready;
  logic              w_mem_ready;
  logic              w_alu_sel;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_nxt;
  logic [ADDR_W-1:0] w_head_reg;
  logic [DATA_W-1:0] w_head_data;
  logic              w_vld [FIFO_DEPTH];
  logic [ADDR_W-1:0] w_ereg [FIFO_DEPTH];
  logic              w_busy;
`ifdef VREG_WB_FWD_EN
  logic [DATA_W-1:0] w_edata [FIFO_DEPTH];
  logic [PW-1:0]     w_rd_ptr;
  logic [DATA_W-1:0] w_fwd_data;
`endif

  vreg_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_reg  (mem_reg),
    .i_push_data (mem_data),
    .i_pop       (w_pop),
    .o_head_reg  (w_head_reg),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_vld       (w_vld),
    .o_reg       (w_ereg)
`ifdef VREG_WB_FWD_EN
    ,
    .o_data      (w_edata),
    .o_rd_ptr    (w_rd_ptr)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= NORM;
    else     r_state <= w_state_nxt;
  end

  // r0 requests still handshake but never enter the FIFO.
  assign w_push = mem_valid && w_mem_ready && (mem_reg != '0);
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_alu_ready = 1'b0;
    w_mem_ready = 1'b0;
    w_alu_sel   = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      NORM: begin
        w_alu_ready = 1'b1;
        w_mem_ready = (w_count < CW'(FIFO_DEPTH));
        w_alu_sel   = alu_valid;
        w_pop       = !alu_valid && (w_count != '0);
        if (w_count_nxt == CW'(FIFO_DEPTH)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_pop = (w_count != '0);
        if (w_count_nxt == '0) w_state_nxt = NORM;
      end
      default: w_state_nxt = NORM;
    endcase
  end

  // Index/data hold their last value while no write is strobed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= 1'b0;
      if (w_alu_sel) begin
        if (alu_reg != '0) begin
          r_reg_write  <= 1'b1;
          r_write_reg  <= alu_reg;
          r_write_data <= alu_data;
        end
      end else if (w_pop) begin
        r_reg_write  <= 1'b1;
        r_write_reg  <= w_head_reg;
        r_write_data <= w_head_data;
      end
    end
  end

  always_comb begin
    w_busy = r_reg_write && (r_write_reg == busy_q_reg);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_vld[i] && (w_ereg[i] == busy_q_reg)) w_busy = 1'b1;
    end
    if (busy_q_reg == '0) w_busy = 1'b0;
  end

`ifdef VREG_WB_FWD_EN
  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    logic [PW-1:0] v_idx;
    w_fwd_data = r_write_data;
    v_idx      = w_rd_ptr;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      v_idx = w_rd_ptr + PW'(k);
      if (w_vld[v_idx] && (w_ereg[v_idx] == busy_q_reg))
        w_fwd_data = w_edata[v_idx];
    end
  end

  assign fwd_hit  = w_busy;
  assign fwd_data = w_fwd_data;
`endif

  assign alu_ready  = w_alu_ready;
  assign mem_ready  = w_mem_ready;
  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign busy_q     = w_busy;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Randomised and directed checks of vreg_wb_arbiter against a
// queue-based reference model of the write-back rules.
module tb_vreg_wb_arbiter;
  import vreg_wb_pkg::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  busy_q_reg;
  logic        busy_q;
  logic [2:0]  fifo_count;
`ifdef VREG_WB_FWD_EN
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  wb_entry_t   m_q[$];
  logic        m_drain;
  logic        m_wr;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  vreg_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_reg    (mem_reg),
    .mem_data   (mem_data),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .busy_q_reg (busy_q_reg),
    .busy_q     (busy_q),
`ifdef VREG_WB_FWD_EN
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .fifo_count (fifo_count)
  );

  task automatic model_reset();
    m_q.delete();
    m_drain = 1'b0;
    m_wr    = 1'b0;
    m_reg   = '0;
    m_data  = '0;
  endtask

  // Inputs are stable from the falling edge; compare, advance one clock.
  task automatic step();
    logic        afire, mfire, pop, hit;
    logic [31:0] fwd;
    wb_entry_t   e;
    #1;
    hit = m_wr && (m_reg == busy_q_reg);
    fwd = m_data;
    foreach (m_q[i]) begin
      if (m_q[i].idx == busy_q_reg) begin
        hit = 1'b1;
        fwd = m_q[i].data;
      end
    end
    if (busy_q_reg == 5'd0) hit = 1'b0;
    checks++;
    if (alu_ready !== !m_drain) begin
      errors++;
      $display("FAIL alu_ready got %b exp %b", alu_ready, !m_drain);
    end
    checks++;
    if (mem_ready !== (!m_drain && m_q.size() < D)) begin
      errors++;
      $display("FAIL mem_ready got %b exp %b", mem_ready,
               (!m_drain && m_q.size() < D));
    end
    checks++;
    if (busy_q !== hit) begin
      errors++;
      $display("FAIL busy_q r%0d got %b exp %b", busy_q_reg, busy_q, hit);
    end
`ifdef VREG_WB_FWD_EN
    checks++;
    if (fwd_hit !== hit || (hit && fwd_data !== fwd)) begin
      errors++;
      $display("FAIL fwd got %b/%h exp %b/%h", fwd_hit, fwd_data, hit, fwd);
    end
`endif
    afire = alu_valid && !m_drain;
    mfire = mem_valid && !m_drain && (m_q.size() < D);
    pop   = (m_q.size() > 0) && (m_drain || !afire);
    m_wr  = 1'b0;
    if (afire) begin
      if (alu_reg != 5'd0) begin
        m_wr   = 1'b1;
        m_reg  = alu_reg;
        m_data = alu_data;
      end
    end else if (pop) begin
      e      = m_q.pop_front();
      m_wr   = 1'b1;
      m_reg  = e.idx;
      m_data = e.data;
    end
    if (mfire && mem_reg != 5'd0) begin
      e.idx  = mem_reg;
      e.data = mem_data;
      m_q.push_back(e);
    end
    if (!m_drain && m_q.size() == D) m_drain = 1'b1;
    else if (m_drain && m_q.size() == 0) m_drain = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (reg_write !== m_wr) begin
      errors++;
      $display("FAIL reg_write got %b exp %b", reg_write, m_wr);
    end
    checks++;
    if (write_reg !== m_reg || write_data !== m_data) begin
      errors++;
      $display("FAIL write got r%0d=%h exp r%0d=%h",
               write_reg, write_data, m_reg, m_data);
    end
    checks++;
    if (fifo_count !== 3'(m_q.size())) begin
      errors++;
      $display("FAIL fifo_count got %0d exp %0d", fifo_count, m_q.size());
    end
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (reg_write !== 1'b0 || write_reg !== 5'd0 ||
        write_data !== 32'd0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset got %b r%0d=%h cnt=%0d exp 0 r0=0 cnt=0",
               reg_write, write_reg, write_data, fifo_count);
    end
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b%b exp 11", alu_ready, mem_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1;
    alu_reg   = 5'd3;
    alu_data  = 32'hA5A5_0001;
    step();
    checks++;
    if (reg_write !== 1'b1 || write_reg !== 5'd3 ||
        write_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL alu_only got %b r%0d=%h exp 1 r3=a5a50001",
               reg_write, write_reg, write_data);
    end
    idle();
    step();
    checks++;
    if (reg_write !== 1'b0 || write_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL alu_hold got %b %h exp 0 a5a50001",
               reg_write, write_data);
    end
  endtask

  task automatic test_mem_burst();
    alu_valid = 1'b1;
    alu_reg   = 5'd5;
    alu_data  = $urandom;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_reg  = 5'(10 + i);
      mem_data = 32'h100 + 32'(i);
      step();
    end
    mem_valid = 1'b0;
    checks++;
    if (alu_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL burst_full got rdy=%b cnt=%0d exp rdy=0 cnt=4",
               alu_ready, fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (reg_write !== 1'b1 || write_reg !== 5'(10 + i) ||
          write_data !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL drain%0d got %b r%0d=%h exp 1 r%0d=%h", i,
                 reg_write, write_reg, write_data, 10 + i, 32'h100 + i);
      end
    end
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_exit alu_ready got %b exp 1", alu_ready);
    end
    idle();
    step();
  endtask

  task automatic test_same_cycle();
    alu_valid  = 1'b1;
    alu_reg    = 5'd6;
    alu_data   = 32'hCAFE_0006;
    mem_valid  = 1'b1;
    mem_reg    = 5'd9;
    mem_data   = 32'hBEEF_0009;
    busy_q_reg = 5'd9;
    step();
    idle();
    checks++;
    if (write_reg !== 5'd6 || busy_q !== 1'b1) begin
      errors++;
      $display("FAIL same_c1 got r%0d busy=%b exp r6 busy=1",
               write_reg, busy_q);
    end
    step();
    checks++;
    if (reg_write !== 1'b1 || write_reg !== 5'd9 ||
        write_data !== 32'hBEEF_0009 || busy_q !== 1'b1) begin
      errors++;
      $display("FAIL same_c2 got %b r%0d=%h busy=%b exp 1 r9 busy=1",
               reg_write, write_reg, write_data, busy_q);
    end
    step();
    checks++;
    if (busy_q !== 1'b0) begin
      errors++;
      $display("FAIL same_c3 busy got %b exp 0", busy_q);
    end
  endtask

  task automatic test_r0();
    busy_q_reg = 5'd0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1;
      alu_reg   = 5'd0;
      alu_data  = $urandom;
      mem_valid = 1'b1;
      mem_reg   = 5'd0;
      mem_data  = $urandom;
      step();
      checks++;
      if (reg_write !== 1'b0 || fifo_count !== 3'd0 || busy_q !== 1'b0) begin
        errors++;
        $display("FAIL r0 got wr=%b cnt=%0d busy=%b exp 0 0 0",
                 reg_write, fifo_count, busy_q);
      end
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_drain();
    alu_valid = 1'b1;
    alu_reg   = 5'd2;
    alu_data  = $urandom;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_reg  = 5'(1 + i);
      mem_data = $urandom;
      step();
    end
    idle();
    step();
    checks++;
    if (fifo_count !== 3'd3 || alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_rst got cnt=%0d rdy=%b exp 3 0",
               fifo_count, alu_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (reg_write !== 1'b0 || fifo_count !== 3'd0 || alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_drain got wr=%b cnt=%0d rdy=%b exp 0 0 1",
               reg_write, fifo_count, alu_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_reg    = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      mem_valid  = ($urandom_range(0, 1) == 0);
      mem_reg    = 5'($urandom_range(0, 7));
      mem_data   = $urandom;
      busy_q_reg = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();
  endtask

`ifdef VREG_WB_FWD_EN
  task automatic test_fwd();
    alu_valid  = 1'b1;
    alu_reg    = 5'd4;
    alu_data   = $urandom;
    mem_valid  = 1'b1;
    busy_q_reg = 5'd7;
    mem_reg    = 5'd7;
    mem_data   = 32'h11;
    step();
    mem_data   = 32'h22;
    step();
    mem_valid  = 1'b0;
    #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_r7 got %b/%h exp 1/22", fwd_hit, fwd_data);
    end
    @(negedge clk);
    idle();
    for (int i = 0; i < 4; i++) step();
  endtask
`endif

  initial begin
    rst        = 1'b1;
    alu_valid  = 1'b0;
    alu_reg    = '0;
    alu_data   = '0;
    mem_valid  = 1'b0;
    mem_reg    = '0;
    mem_data   = '0;
    busy_q_reg = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_alu_only();
    test_mem_burst();
    test_same_cycle();
    test_r0();
    test_reset_mid_drain();
`ifdef VREG_WB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
